ifetch_queue: RTL and testbench

//  Parametrised instruction-fetch unit. It sits between the memory controller and the decoder.
//  - Issues one instruction-read request at a time and buffers returned instructions in an IQ_DEPTH FIFO.
//  - Redirects immediately on JAL and predicts conditional branches with a 2-bit-counter BHT.
//  - Stalls on JALR until its target is resolved; flushes on roll_back.

---
 rtl/ifetch_queue_pkg.sv | 25 ++
 rtl/ifetch_queue_if.sv | 35 +++
 rtl/ifetch_queue_bht.sv | 37 +++
 rtl/ifetch_queue.sv | 169 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   - RV32 opcodes that change the fetch stream (JAL, conditional branch, JALR)
//   - fetch FSM state encoding
//   - J-type and B-type immediate extraction, sign-extended to 32 bits
package ifetch_queue_pkg;

   localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
   localparam logic [6:0] OPCODE_B    = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR = 7'b1100111;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT       = 2'd1,
      ST_JALR_STALL = 2'd2
   } fetch_state_t;

   function automatic logic signed [31:0] j_imm(input logic [31:0] instr);
      return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   function automatic logic signed [31:0] b_imm(input logic [31:0] instr);
      return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Memory-controller and decoder handshake bundle of the fetch unit.
//   mc_aout_en / mc_aout           : read request and address (fetch -> memory)
//   mc_instr_in_en / mc_instr_in   : one-cycle response strobe and word (memory -> fetch)
//   de_stall                       : decoder back-pressure (decoder -> fetch)
//   de_out_en / de_pc_out /
//   de_instr_out / de_pred_jump_out: issued instruction (fetch -> decoder)
// modport master is the fetch unit, modport slave is its environment.
interface ifetch_queue_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic               mc_aout_en;
   logic [ADDR_W-1:0]  mc_aout;
   logic               mc_instr_in_en;
   logic [INSTR_W-1:0] mc_instr_in;
   logic               de_stall;
   logic               de_out_en;
   logic [ADDR_W-1:0]  de_pc_out;
   logic [INSTR_W-1:0] de_instr_out;
   logic               de_pred_jump_out;

   modport master (
      output mc_aout_en, mc_aout,
      input  mc_instr_in_en, mc_instr_in,
      input  de_stall,
      output de_out_en, de_pc_out, de_instr_out, de_pred_jump_out
   );

   modport slave (
      input  mc_aout_en, mc_aout,
      output mc_instr_in_en, mc_instr_in,
      output de_stall,
      input  de_out_en, de_pc_out, de_instr_out, de_pred_jump_out
   );
endinterface

// File: rtl/ifetch_queue_bht.sv
// Branch history table: 2^BHT_IDX two-bit saturating counters.
//   clk, rst_in : clock, synchronous active-high reset (all counters -> 2'b01)
//   rd_idx      : combinational lookup index
//   rd_taken    : MSB of the addressed counter (1 = predict taken)
//   we, wr_idx, wr_taken : synchronous counter update (inc if taken, else dec)
// A lookup of an index being written in the same cycle returns the old value.
module ifetch_queue_bht #(
   parameter int BHT_IDX = 6
) (
   input  logic               clk,
   input  logic               rst_in,
   input  logic [BHT_IDX-1:0] rd_idx,
   output logic               rd_taken,
   input  logic               we,
   input  logic [BHT_IDX-1:0] wr_idx,
   input  logic               wr_taken
);

   localparam int N = 1 << BHT_IDX;

   logic [1:0] ctr [N];

   assign rd_taken = ctr[rd_idx][1];

   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int i = 0; i < N; i++) ctr[i] <= 2'b01;
      end else if (we) begin
         if (wr_taken) begin
            if (ctr[wr_idx] != 2'b11) ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
         end else begin
            if (ctr[wr_idx] != 2'b00) ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
         end
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch unit between the memory controller and the decoder.
// Issues one read at a time, buffers returned words in an IQ_DEPTH FIFO,
// follows JAL immediately, predicts conditional branches with a BHT and
// stalls on JALR until its target is resolved.
//   clk, rst_in          : clock, synchronous active-high reset
//   rdy_in               : low freezes all state (reset and roll_back still act)
//   roll_back, corr_pc   : flush queue and restart fetch at corr_pc
//   bus (master)         : memory request/response and decoder issue signals
//   jalr_done, jalr_pc   : resolved JALR target
//   br_upd_en/pc/taken   : committed conditional branch outcome for the BHT
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int IQ_DEPTH = 8,
   parameter int BHT_IDX  = 6,
   parameter int ADDR_W   = 32,
   parameter int INSTR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              roll_back,
   input  logic [ADDR_W-1:0] corr_pc,
   ifetch_queue_if.master    bus,
   input  logic              jalr_done,
   input  logic [ADDR_W-1:0] jalr_pc,
   input  logic              br_upd_en,
   input  logic [ADDR_W-1:0] br_upd_pc,
   input  logic              br_upd_taken
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
      logic               pred;
   } iq_entry_t;

   iq_entry_t          iq_mem [IQ_DEPTH];
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [CNT_W-1:0]   count_q;

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic               aout_en_d;
   logic [ADDR_W-1:0]  aout_d;
   logic               push, push_pred, pop, iq_write;

   logic [6:0]         opcode;
   logic [ADDR_W-1:0]  imm_j, imm_b;
   logic               bht_taken;
   logic               bht_we;
   logic               unused_upd_bits;

   assign opcode = bus.mc_instr_in[6:0];
   assign imm_j  = ADDR_W'(j_imm(bus.mc_instr_in[31:0]));
   assign imm_b  = ADDR_W'(b_imm(bus.mc_instr_in[31:0]));

   // Counter updates follow the commit stream, so they are frozen with the
   // rest of the unit but still land in a roll_back cycle.
   assign bht_we = br_upd_en & (rdy_in | roll_back);
   assign unused_upd_bits = ^{br_upd_pc[ADDR_W-1:BHT_IDX+2], br_upd_pc[1:0]};

   ifetch_queue_bht #(.BHT_IDX(BHT_IDX)) u_bht (
      .clk      (clk),
      .rst_in   (rst_in),
      .rd_idx   (fetch_pc_q[BHT_IDX+1:2]),
      .rd_taken (bht_taken),
      .we       (bht_we),
      .wr_idx   (br_upd_pc[BHT_IDX+1:2]),
      .wr_taken (br_upd_taken)
   );

   // Pop decision uses the count before this cycle's push, so a freshly
   // pushed entry is visible to the decoder one cycle later at the earliest.
   assign pop = (count_q != '0) && !bus.de_stall;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      aout_en_d  = bus.mc_aout_en;
      aout_d     = bus.mc_aout;
      push       = 1'b0;
      push_pred  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Only one request is ever in flight, so a free slot now is
            // still free when its response is pushed.
            if (count_q < CNT_W'(IQ_DEPTH)) begin
               aout_en_d = 1'b1;
               aout_d    = fetch_pc_q;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mc_instr_in_en) begin
               push      = 1'b1;
               aout_en_d = 1'b0;
               state_d   = ST_IDLE;
               case (opcode)
                  OPCODE_JAL:  fetch_pc_d = fetch_pc_q + imm_j;
                  OPCODE_B: begin
                     push_pred  = bht_taken;
                     fetch_pc_d = bht_taken ? fetch_pc_q + imm_b
                                            : fetch_pc_q + ADDR_W'(4);
                  end
                  OPCODE_JALR: state_d = ST_JALR_STALL;
                  default:     fetch_pc_d = fetch_pc_q + ADDR_W'(4);
               endcase
            end
         end
         ST_JALR_STALL: begin
            if (jalr_done) begin
               fetch_pc_d = jalr_pc;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q              <= ST_IDLE;
         fetch_pc_q           <= '0;
         bus.mc_aout_en       <= 1'b0;
         bus.mc_aout          <= '0;
         head_q               <= '0;
         tail_q               <= '0;
         count_q              <= '0;
         bus.de_out_en        <= 1'b0;
         bus.de_pc_out        <= '0;
         bus.de_instr_out     <= '0;
         bus.de_pred_jump_out <= 1'b0;
      end else if (roll_back) begin
         // Any response arriving now belongs to the aborted stream.
         state_q        <= ST_IDLE;
         fetch_pc_q     <= corr_pc;
         bus.mc_aout_en <= 1'b0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         bus.de_out_en  <= 1'b0;
      end else if (rdy_in) begin
         state_q        <= state_d;
         fetch_pc_q     <= fetch_pc_d;
         bus.mc_aout_en <= aout_en_d;
         bus.mc_aout    <= aout_d;
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop) begin
            head_q               <= head_q + PTR_W'(1);
            bus.de_pc_out        <= iq_mem[head_q].pc;
            bus.de_instr_out     <= iq_mem[head_q].instr;
            bus.de_pred_jump_out <= iq_mem[head_q].pred;
         end
         bus.de_out_en <= pop;
         count_q       <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign iq_write = push & rdy_in & ~roll_back & ~rst_in;

   always_ff @(posedge clk) begin
      if (iq_write) iq_mem[tail_q] <= '{pc: fetch_pc_q, instr: bus.mc_instr_in, pred: push_pred};
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a queue-based model.
module tb_ifetch_queue;
   import ifetch_queue_pkg::*;

   localparam int IQ_DEPTH = 8;
   localparam int S_IDLE = 0, S_WAIT = 1, S_JST = 2;
   localparam int K_ALU = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_in, rdy_in, roll_back, jalr_done, br_upd_en, br_upd_taken;
   logic [31:0] corr_pc, jalr_pc, br_upd_pc;

   ifetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

   ifetch_queue #(.IQ_DEPTH(IQ_DEPTH), .BHT_IDX(6), .ADDR_W(32), .INSTR_W(32)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back), .corr_pc(corr_pc),
      .bus(bus), .jalr_done(jalr_done), .jalr_pc(jalr_pc),
      .br_upd_en(br_upd_en), .br_upd_pc(br_upd_pc), .br_upd_taken(br_upd_taken)
   );

   // Program memory: what kind of instruction lives at each word and its offset.
   int          kind [256];
   logic [31:0] offs [256];
   logic [31:0] words[256];

   typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic pred; } ent_t;
   ent_t        m_q[$];
   int          m_state;
   logic [31:0] m_fpc, m_aout, m_de_pc, m_de_instr;
   logic        m_aen, m_de_en, m_de_pred;
   int          m_bht[64];

   int n_tests = 0, n_fail = 0, cyc = 0;
   bit chk_en = 0, auto_jalr = 0, rnd_lat = 0;
   int rsp_wait = 0, rsp_lat = 0, jw = 0, jl = 0;

   logic [31:0] obs_req[$], obs_pc[$];
   logic        obs_pred[$];
   int          obs_cyc[$];
   logic        prev_aen = 1'b0;
   logic [31:0] exp_a[11];

   function automatic logic [31:0] enc(int k, int off);
      logic [20:0] j;
      logic [12:0] b;
      j = off[20:0];
      b = off[12:0];
      case (k)
         K_BR:   return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], OPCODE_B};
         K_JAL:  return {j[20], j[10:1], j[11], j[19:12], 5'd1, OPCODE_JAL};
         K_JALR: return {12'd0, 5'd1, 3'b000, 5'd0, OPCODE_JALR};
         default: return {j[11:0], 5'd1, 3'b000, 5'd1, 7'b0010011};
      endcase
   endfunction

   task automatic set_mem(int idx, int k, int off);
      kind[idx]  = k;
      offs[idx]  = off;
      words[idx] = enc(k, off);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_true(input string name, input bit cond);
      n_tests++;
      if (!cond) begin
         n_fail++;
         $display("FAIL %s: condition false, required true (cycle %0d)", name, cyc);
      end
   endtask

   // Reference model: advance one clock edge from the inputs applied to it.
   task automatic model_step();
      ent_t e;
      int   idx;
      bit   pred, pop_ok, start_ok;
      if (rst_in) begin
         m_q.delete();
         m_state = S_IDLE; m_fpc = 0; m_aout = 0; m_aen = 0;
         m_de_en = 0; m_de_pc = 0; m_de_instr = 0; m_de_pred = 0;
         foreach (m_bht[i]) m_bht[i] = 1;
         return;
      end
      pred = (m_bht[m_fpc[7:2]] >= 2);
      if (roll_back) begin
         m_q.delete();
         m_de_en = 0; m_aen = 0; m_fpc = corr_pc; m_state = S_IDLE;
      end else if (rdy_in) begin
         start_ok = (m_q.size() < IQ_DEPTH);
         pop_ok   = (m_q.size() > 0) && !bus.de_stall;
         if (pop_ok) begin
            e = m_q.pop_front();
            m_de_pc = e.pc; m_de_instr = e.instr; m_de_pred = e.pred;
         end
         m_de_en = pop_ok;
         if (m_state == S_IDLE) begin
            if (start_ok) begin m_aen = 1; m_aout = m_fpc; m_state = S_WAIT; end
         end else if (m_state == S_WAIT) begin
            if (bus.mc_instr_in_en) begin
               idx = int'(m_fpc[9:2]);
               e.pc = m_fpc; e.instr = bus.mc_instr_in; e.pred = (kind[idx] == K_BR) && pred;
               m_q.push_back(e);
               m_aen = 0;
               m_state = S_IDLE;
               case (kind[idx])
                  K_JAL:   m_fpc = m_fpc + offs[idx];
                  K_BR:    m_fpc = pred ? m_fpc + offs[idx] : m_fpc + 4;
                  K_JALR:  m_state = S_JST;
                  default: m_fpc = m_fpc + 4;
               endcase
            end
         end else begin
            if (jalr_done) begin m_fpc = jalr_pc; m_state = S_IDLE; end
         end
      end
      if (br_upd_en && (rdy_in || roll_back)) begin
         idx = int'(br_upd_pc[7:2]);
         if (br_upd_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
         else              m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
      end
   endtask

   // Memory controller and JALR resolver, reacting to the model's request state.
   task automatic drive_env();
      if (m_aen) begin
         bus.mc_instr_in_en = (rsp_wait >= rsp_lat);
         bus.mc_instr_in    = words[m_aout[9:2]];
         rsp_wait++;
      end else begin
         bus.mc_instr_in_en = 1'b0;
         rsp_wait = 0;
         rsp_lat  = rnd_lat ? int'($urandom_range(0, 3)) : 0;
      end
      if (auto_jalr) begin
         if (m_state == S_JST) begin
            jalr_done = (jw >= jl);
            jw++;
         end else begin
            jalr_done = 1'b0;
            jw = 0;
            jl = int'($urandom_range(0, 4));
            jalr_pc = $urandom_range(0, 255) << 2;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      drive_env();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_req.delete(); obs_pc.delete(); obs_pred.delete(); obs_cyc.delete();
   endtask

   task automatic rollback_to(input logic [31:0] pc);
      roll_back = 1'b1; corr_pc = pc;
      step();
      roll_back = 1'b0;
      clear_obs();
   endtask

   task automatic run_req(int n, int budget, string tag);
      int k = 0;
      while (obs_req.size() < n && k < budget) begin step(); k++; end
      chk_true({tag, " request timeout"}, obs_req.size() >= n);
   endtask

   task automatic run_pc(int n, int budget, string tag);
      int k = 0;
      while (obs_pc.size() < n && k < budget) begin step(); k++; end
      chk_true({tag, " issue timeout"}, obs_pc.size() >= n);
   endtask

   function automatic logic [31:0] req_at(int i);
      return (i < obs_req.size()) ? obs_req[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pc_at(int i);
      return (i < obs_pc.size()) ? obs_pc[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic pred_at(int i);
      return (i < obs_pred.size()) ? obs_pred[i] : 1'bx;
   endfunction

   // Per-cycle comparison against the model plus observation logs.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("mc_aout_en", bus.mc_aout_en, m_aen);
            chk("mc_aout", bus.mc_aout, m_aout);
            chk("de_out_en", bus.de_out_en, m_de_en);
            chk("de_pc_out", bus.de_pc_out, m_de_pc);
            chk("de_instr_out", bus.de_instr_out, m_de_instr);
            chk("de_pred_jump_out", bus.de_pred_jump_out, m_de_pred);
            if (bus.mc_aout_en && !prev_aen) obs_req.push_back(bus.mc_aout);
            prev_aen = bus.mc_aout_en;
            if (bus.de_out_en) begin
               obs_pc.push_back(bus.de_pc_out);
               obs_pred.push_back(bus.de_pred_jump_out);
               obs_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      bit found;
      int r, off;
      rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; corr_pc = 0;
      jalr_done = 1'b0; jalr_pc = 0; br_upd_en = 1'b0; br_upd_pc = 0; br_upd_taken = 1'b0;
      bus.mc_instr_in_en = 1'b0; bus.mc_instr_in = 0; bus.de_stall = 1'b0;
      for (int i = 0; i < 256; i++) set_mem(i, K_ALU, i);
      set_mem(4, K_JAL, 32);    // 0x10: jal +0x20
      set_mem(16, K_BR, -8);    // 0x40: beq -8
      set_mem(32, K_JALR, 0);   // 0x80: jalr
      exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44};

      step(); chk_en = 1; step();
      chk("reset mc_aout_en", bus.mc_aout_en, 0);
      chk("reset mc_aout", bus.mc_aout, 0);
      chk("reset de_out_en", bus.de_out_en, 0);
      chk("reset de_pc_out", bus.de_pc_out, 0);
      rst_in = 1'b0;

      // Sequential fetch, JAL redirect, branch with a fresh BHT.
      run_req(11, 200, "A");
      for (int i = 0; i < 11; i++) chk($sformatf("A req[%0d]", i), req_at(i), exp_a[i]);
      found = 0;
      foreach (obs_req[i]) if (obs_req[i] == 32'h14) found = 1;
      chk_true("A 0x14 not fetched", !found);
      run_pc(10, 100, "A");
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("A de_pc[%0d]", i), pc_at(i), 4 * i);
         chk($sformatf("A pred[%0d]", i), pred_at(i), 0);
      end
      chk("A beq pc", pc_at(9), 32'h40);
      chk("A beq pred fresh", pred_at(9), 0);

      // Train 0x40 taken twice -> predicted taken.
      br_upd_en = 1'b1; br_upd_pc = 32'h40; br_upd_taken = 1'b1;
      step(); step();
      br_upd_en = 1'b0;
      rollback_to(32'h40);
      chk("B rollback de_out_en", bus.de_out_en, 0);
      chk("B rollback mc_aout_en", bus.mc_aout_en, 0);
      run_req(2, 50, "B");
      chk("B req0", req_at(0), 32'h40);
      chk("B req1 taken", req_at(1), 32'h38);
      run_pc(1, 50, "B");
      chk("B pred", pred_at(0), 1);

      // Saturate at 3, one not-taken -> 2, still taken.
      br_upd_en = 1'b1; br_upd_taken = 1'b1;
      step(); step();
      br_upd_taken = 1'b0;
      step();
      br_upd_en = 1'b0;
      rollback_to(32'h40);
      run_req(2, 50, "C");
      chk("C req1 taken", req_at(1), 32'h38);
      run_pc(1, 50, "C");
      chk("C pred", pred_at(0), 1);

      // Full queue under decoder stall, then drain.
      bus.de_stall = 1'b1;
      rollback_to(32'h100);
      repeat (30) step();
      chk("D requests while stalled", obs_req.size(), 8);
      chk("D mc_aout_en idle", bus.mc_aout_en, 0);
      chk("D no issue while stalled", obs_pc.size(), 0);
      bus.de_stall = 1'b0;
      repeat (20) step();
      for (int i = 0; i < 10; i++) chk($sformatf("D de_pc[%0d]", i), pc_at(i), 32'h100 + 4 * i);
      chk_true("D 8 back-to-back", obs_cyc.size() >= 8 && obs_cyc[7] - obs_cyc[0] == 7);

      // JALR stall until resolved.
      rollback_to(32'h80);
      repeat (20) step();
      chk("D2 jalr requests", obs_req.size(), 1);
      chk("E jalr req0", req_at(0), 32'h80);
      chk("E stall mc_aout_en", bus.mc_aout_en, 0);
      jalr_done = 1'b1; jalr_pc = 32'h200;
      step();
      jalr_done = 1'b0;
      run_req(2, 50, "E");
      chk("E jalr target", req_at(1), 32'h200);

      // 5 queued + outstanding request, freeze, then roll_back.
      bus.de_stall = 1'b1;
      rollback_to(32'h300);
      begin
         int k = 0;
         while (!(m_q.size() == 5 && m_aen) && k < 100) begin step(); k++; end
      end
      chk_true("F setup reached", m_q.size() == 5 && m_aen);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("F frozen mc_aout_en", bus.mc_aout_en, 1);
         chk("F frozen mc_aout", bus.mc_aout, 32'h314);
         chk("F frozen de_out_en", bus.de_out_en, 0);
      end
      rdy_in = 1'b1;
      rollback_to(32'h1000);
      chk("F flush de_out_en", bus.de_out_en, 0);
      chk("F flush mc_aout_en", bus.mc_aout_en, 0);
      run_req(1, 50, "F");
      chk("F restart req", req_at(0), 32'h1000);
      bus.de_stall = 1'b0;
      run_pc(1, 50, "F");
      chk("F first issue after flush", pc_at(0), 32'h1000);

      // Randomized program and environment.
      rst_in = 1'b1;
      step();
      for (int i = 0; i < 256; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) set_mem(i, K_ALU, int'($urandom_range(0, 2047)));
         else if (r < 75) set_mem(i, K_BR, (int'($urandom_range(0, 63)) - 32) * 4);
         else if (r < 90) begin
            off = (int'($urandom_range(0, 127)) - 64) * 4;
            if (off == 0) off = 4;
            set_mem(i, K_JAL, off);
         end else set_mem(i, K_JALR, 0);
      end
      auto_jalr = 1; rnd_lat = 1;
      step();
      rst_in = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rdy_in       = ($urandom_range(0, 9) != 0);
         bus.de_stall = ($urandom_range(0, 3) == 0);
         roll_back    = ($urandom_range(0, 39) == 0);
         corr_pc      = $urandom_range(0, 255) << 2;
         br_upd_en    = ($urandom_range(0, 4) == 0);
         br_upd_pc    = $urandom_range(0, 255) << 2;
         br_upd_taken = $urandom_range(0, 1);
         step();
      end
      roll_back = 1'b0; br_upd_en = 1'b0; rdy_in = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
